// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory access stage
//
// Holds the stage FSM encoding, the datapath width, the wait-counter width
// and the default dm_ack timeout. No ports; imported by the interface and
// the stage top.
package mem_pkg;

    localparam int XLEN            = 64;
    localparam int WAIT_W          = 10;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    // Doubleword accesses only: the low three address bits must be zero.
    function automatic logic is_dword_aligned(input logic [2:0] addr_lo);
        return addr_lo == 3'b000;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/response bus
//
// Signals:
//   dm_req    request strobe, held until the ack cycle
//   dm_we     write enable (valid while dm_req)
//   dm_addr   byte address (valid while dm_req)
//   dm_wdata  store data (valid while dm_req)
//   dm_ack    one-cycle completion pulse from memory
//   dm_rdata  load data, valid with dm_ack
// Modports: master = pipeline stage, slave = memory.
interface mem_access_stage_if;
    import mem_pkg::*;

    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic            dm_ack;
    logic [XLEN-1:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );

endinterface

// File: rtl/flopenr.sv
// rtl/flopenr.sv - enabled register with asynchronous active-high reset
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears q
//   en     load enable
//   d      next value
//   q      registered value
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory stage with data-memory handshake
//
// Captures execute-stage results, performs at most one data-memory access per
// instruction, and hands results to writeback with a one-cycle valid_M pulse.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   valid_E                         execute stage presents an instruction
//   Branch_E, memRead_E, memWrite_E control bits
//   PCBranch_E, aluResult_E,
//   writeData_E, zero_E             execute results
//   stall_M                         upstream must hold its inputs
//   dm (master)                     data-memory request/response bus
//   valid_M                         writeback results complete (pulse)
//   aluResult_M, readData_M         writeback results
//   PCSrc_M, PCBranch_M             branch select and target
//   align_fault, bus_error          one-cycle error pulses
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_E,
    input  logic               Branch_E,
    input  logic               memRead_E,
    input  logic               memWrite_E,
    input  logic [XLEN-1:0]    PCBranch_E,
    input  logic [XLEN-1:0]    aluResult_E,
    input  logic [XLEN-1:0]    writeData_E,
    input  logic               zero_E,
    output logic               stall_M,
    mem_access_stage_if.master dm,
    output logic               valid_M,
    output logic [XLEN-1:0]    aluResult_M,
    output logic [XLEN-1:0]    readData_M,
    output logic               PCSrc_M,
    output logic [XLEN-1:0]    PCBranch_M,
    output logic               align_fault,
    output logic               bus_error
);

    // Counter value seen in the last ACCESS cycle allowed before abort.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    mem_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              dm_req_q, dm_req_d;
    logic              valid_q, valid_d;
    logic              pcsrc_q, pcsrc_d;
    logic              align_fault_q, align_fault_d;
    logic              bus_error_q, bus_error_d;

    logic              branch_m, memread_m, memwrite_m, zero_m;
    logic [XLEN-1:0]   pcbranch_m, alu_m, wdata_m, rdata_m;

    logic              capture_en;
    logic              rdata_en;

    // Capture only happens in IDLE and DONE. The ack cycle also drops stall_M,
    // but the M registers still feed the DONE cycle that follows, so they
    // cannot be overwritten there.
    assign capture_en = valid_E && (state_q != ACCESS);

    // Both memRead and memWrite set is a store, so it never loads readData_M.
    assign rdata_en = (state_q == ACCESS) && dm.dm_ack && memread_m && !memwrite_m;

    flopenr #(.WIDTH(1)) u_branch_m (
        .clk(clk), .reset(reset), .en(capture_en), .d(Branch_E), .q(branch_m)
    );
    flopenr #(.WIDTH(1)) u_memread_m (
        .clk(clk), .reset(reset), .en(capture_en), .d(memRead_E), .q(memread_m)
    );
    flopenr #(.WIDTH(1)) u_memwrite_m (
        .clk(clk), .reset(reset), .en(capture_en), .d(memWrite_E), .q(memwrite_m)
    );
    flopenr #(.WIDTH(1)) u_zero_m (
        .clk(clk), .reset(reset), .en(capture_en), .d(zero_E), .q(zero_m)
    );
    flopenr #(.WIDTH(XLEN)) u_pcbranch_m (
        .clk(clk), .reset(reset), .en(capture_en), .d(PCBranch_E), .q(pcbranch_m)
    );
    flopenr #(.WIDTH(XLEN)) u_alu_m (
        .clk(clk), .reset(reset), .en(capture_en), .d(aluResult_E), .q(alu_m)
    );
    flopenr #(.WIDTH(XLEN)) u_wdata_m (
        .clk(clk), .reset(reset), .en(capture_en), .d(writeData_E), .q(wdata_m)
    );
    flopenr #(.WIDTH(XLEN)) u_rdata_m (
        .clk(clk), .reset(reset), .en(rdata_en), .d(dm.dm_rdata), .q(rdata_m)
    );

    // Next-state and next-output logic. Every registered output defaults to
    // zero so pulses last exactly one cycle.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        dm_req_d      = 1'b0;
        valid_d       = 1'b0;
        pcsrc_d       = 1'b0;
        align_fault_d = 1'b0;
        bus_error_d   = 1'b0;

        unique case (state_q)
            ACCESS: begin
                if (dm.dm_ack) begin
                    // Ack wins over timeout when both land on the same cycle.
                    state_d = DONE;
                    valid_d = 1'b1;
                    pcsrc_d = branch_m & zero_m;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = DONE;
                    bus_error_d = 1'b1;
                    pcsrc_d     = branch_m & zero_m;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    dm_req_d   = 1'b1;
                end
            end

            default: begin
                // IDLE and DONE behave the same: capture if offered, else idle.
                if (valid_E) begin
                    if (memRead_E || memWrite_E) begin
                        if (is_dword_aligned(aluResult_E[2:0])) begin
                            state_d    = ACCESS;
                            wait_cnt_d = '0;
                            dm_req_d   = 1'b1;
                        end else begin
                            state_d       = DONE;
                            align_fault_d = 1'b1;
                            pcsrc_d       = Branch_E & zero_E;
                        end
                    end else begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        pcsrc_d = Branch_E & zero_E;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            dm_req_q      <= 1'b0;
            valid_q       <= 1'b0;
            pcsrc_q       <= 1'b0;
            align_fault_q <= 1'b0;
            bus_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            dm_req_q      <= dm_req_d;
            valid_q       <= valid_d;
            pcsrc_q       <= pcsrc_d;
            align_fault_q <= align_fault_d;
            bus_error_q   <= bus_error_d;
        end
    end

    // The ack cycle releases the stall combinationally so upstream can move on.
    assign stall_M     = (state_q == ACCESS) && !dm.dm_ack;

    assign dm.dm_req   = dm_req_q;
    assign dm.dm_we    = dm_req_q & memwrite_m;
    assign dm.dm_addr  = alu_m;
    assign dm.dm_wdata = wdata_m;

    assign valid_M     = valid_q;
    assign aluResult_M = alu_m;
    assign readData_M  = rdata_m;
    assign PCSrc_M     = pcsrc_q;
    assign PCBranch_M  = pcbranch_m;
    assign align_fault = align_fault_q;
    assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

    localparam int TO = 4;

    typedef struct {
        logic        br;
        logic        rd;
        logic        wr;
        logic        z;
        logic [63:0] pcb;
        logic [63:0] alu;
        logic [63:0] wd;
        logic [63:0] rdata;
        int          ack_dly;
        int          gap;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_E, Branch_E, memRead_E, memWrite_E, zero_E;
    logic [63:0] PCBranch_E, aluResult_E, writeData_E;
    logic        stall_M, valid_M, PCSrc_M, align_fault, bus_error;
    logic [63:0] aluResult_M, readData_M, PCBranch_M;

    int          n_assert;
    int          n_fail;
    logic [63:0] exp_rd;
    instr_t      q[$];

    mem_access_stage_if dm();

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .valid_E(valid_E),
        .Branch_E(Branch_E), .memRead_E(memRead_E), .memWrite_E(memWrite_E),
        .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E), .writeData_E(writeData_E),
        .zero_E(zero_E), .stall_M(stall_M), .dm(dm), .valid_M(valid_M),
        .aluResult_M(aluResult_M), .readData_M(readData_M), .PCSrc_M(PCSrc_M),
        .PCBranch_M(PCBranch_M), .align_fault(align_fault), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic instr_t mk(input logic br, rd, wr, z, input logic [63:0] pcb, alu, wd,
                                  input int ack_dly, input logic [63:0] rdata, input int gap);
        instr_t t;
        t.br = br; t.rd = rd; t.wr = wr; t.z = z;
        t.pcb = pcb; t.alu = alu; t.wd = wd;
        t.ack_dly = ack_dly; t.rdata = rdata; t.gap = gap;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int kind;
        kind    = $urandom_range(0, 4);
        t.br    = (kind == 4) ? 1'b1 : 1'($urandom_range(0, 1));
        t.rd    = (kind == 1) || (kind == 3);
        t.wr    = (kind == 2) || (kind == 3);
        t.z     = 1'($urandom_range(0, 1));
        t.pcb   = rnd64();
        t.alu   = rnd64();
        if ($urandom_range(0, 3) != 0) t.alu[2:0] = 3'b000;
        t.wd    = rnd64();
        t.rdata = rnd64();
        t.ack_dly = $urandom_range(1, TO + 2);
        t.gap   = $urandom_range(0, 2);
        return t;
    endfunction

    task automatic drive_instr(input instr_t t);
        valid_E     = 1'b1;
        Branch_E    = t.br;
        memRead_E   = t.rd;
        memWrite_E  = t.wr;
        zero_E      = t.z;
        PCBranch_E  = t.pcb;
        aluResult_E = t.alu;
        writeData_E = t.wd;
    endtask

    // Garbage on the E inputs while valid_E is low must never be captured.
    task automatic scramble_e();
        valid_E     = 1'b0;
        Branch_E    = 1'($urandom_range(0, 1));
        memRead_E   = 1'($urandom_range(0, 1));
        memWrite_E  = 1'($urandom_range(0, 1));
        zero_E      = 1'($urandom_range(0, 1));
        PCBranch_E  = rnd64();
        aluResult_E = rnd64();
        writeData_E = rnd64();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, stall_M, 0);
        chk({tag, "_valid"}, valid_M, 0);
        chk({tag, "_alu"}, aluResult_M, 0);
        chk({tag, "_rd"}, readData_M, 0);
        chk({tag, "_pcsrc"}, PCSrc_M, 0);
        chk({tag, "_pcb"}, PCBranch_M, 0);
        chk({tag, "_af"}, align_fault, 0);
        chk({tag, "_be"}, bus_error, 0);
        chk({tag, "_req"}, dm.dm_req, 0);
        chk({tag, "_we"}, dm.dm_we, 0);
        chk({tag, "_addr"}, dm.dm_addr, 0);
        chk({tag, "_wdata"}, dm.dm_wdata, 0);
    endtask

    // Stray acks while idle must be ignored.
    task automatic idle_cycle();
        dm.dm_ack   = 1'($urandom_range(0, 1));
        dm.dm_rdata = rnd64();
        @(negedge clk);
        chk("idle_req", dm.dm_req, 0);
        chk("idle_stall", stall_M, 0);
        chk("idle_valid", valid_M, 0);
        chk("idle_pcsrc", PCSrc_M, 0);
        chk("idle_af", align_fault, 0);
        chk("idle_be", bus_error, 0);
        chk("idle_rd", readData_M, exp_rd);
        @(posedge clk); #1;
        dm.dm_ack = 1'b0;
    endtask

    // Entered just after cur was captured; returns just after the next capture
    // (or after DONE when there is no next instruction).
    task automatic exec(input instr_t cur, input instr_t nxt, input bit has_next);
        bit mem, ok, acked, tmo, flt;
        int n;
        scramble_e();
        mem = cur.rd | cur.wr;
        ok  = mem && (cur.alu[2:0] == 3'b000);
        n   = 0;
        if (ok) n = (cur.ack_dly <= TO) ? cur.ack_dly : TO;
        for (int k = 1; k <= n; k++) begin
            dm.dm_ack   = (k == cur.ack_dly);
            dm.dm_rdata = (k == cur.ack_dly) ? cur.rdata : rnd64();
            @(negedge clk);
            chk("acc_req", dm.dm_req, 1);
            chk("acc_addr", dm.dm_addr, cur.alu);
            chk("acc_we", dm.dm_we, cur.wr);
            chk("acc_wdata", dm.dm_wdata, cur.wd);
            chk("acc_stall", stall_M, (k == cur.ack_dly) ? 64'd0 : 64'd1);
            chk("acc_valid", valid_M, 0);
            chk("acc_pcsrc", PCSrc_M, 0);
            @(posedge clk); #1;
            dm.dm_ack = 1'b0;
        end
        acked = ok && (cur.ack_dly <= TO);
        tmo   = ok && !acked;
        flt   = mem && !ok;
        if (acked && cur.rd && !cur.wr) exp_rd = cur.rdata;
        if (has_next && nxt.gap == 0) drive_instr(nxt);
        @(negedge clk);
        chk("done_valid", valid_M, (!mem || acked) ? 64'd1 : 64'd0);
        chk("done_af", align_fault, flt);
        chk("done_be", bus_error, tmo);
        chk("done_pcsrc", PCSrc_M, cur.br & cur.z);
        chk("done_pcb", PCBranch_M, cur.pcb);
        chk("done_alu", aluResult_M, cur.alu);
        chk("done_rd", readData_M, exp_rd);
        chk("done_req", dm.dm_req, 0);
        chk("done_stall", stall_M, 0);
        @(posedge clk); #1;
        if (has_next && nxt.gap != 0) begin
            scramble_e();
            for (int g = 0; g < nxt.gap; g++) idle_cycle();
            drive_instr(nxt);
            @(negedge clk);
            chk("cap_stall", stall_M, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_q();
        drive_instr(q[0]);
        @(negedge clk);
        chk("cap_stall", stall_M, 0);
        @(posedge clk); #1;
        for (int i = 0; i < q.size(); i++) begin
            if (i + 1 < q.size()) exec(q[i], q[i + 1], 1'b1);
            else                  exec(q[i], q[i], 1'b0);
        end
        scramble_e();
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        exp_rd      = 64'd0;
        reset       = 1'b1;
        valid_E     = 1'b0;
        Branch_E    = 1'b0;
        memRead_E   = 1'b0;
        memWrite_E  = 1'b0;
        zero_E      = 1'b0;
        PCBranch_E  = 64'd0;
        aluResult_E = 64'd0;
        writeData_E = 64'd0;
        dm.dm_ack   = 1'b0;
        dm.dm_rdata = 64'd0;

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;

        // Directed: ADD, LDUR, misaligned STUR, CBZ taken/not, timeout,
        // aligned store, read+write as store, misaligned load, ack at the
        // timeout boundary, ack one past it.
        q.push_back(mk(0, 0, 0, 0, 64'h0,   64'h10, 64'h0,        1,   64'h0,        0));
        q.push_back(mk(0, 1, 0, 0, 64'h0,   64'h40, 64'h0,        3,   64'hDEADBEEF, 1));
        q.push_back(mk(0, 0, 1, 0, 64'h0,   64'h43, 64'h1234,     1,   64'h0,        1));
        q.push_back(mk(1, 0, 0, 1, 64'h200, 64'h0,  64'h0,        1,   64'h0,        0));
        q.push_back(mk(1, 0, 0, 0, 64'h200, 64'h8,  64'h0,        1,   64'h0,        0));
        q.push_back(mk(0, 1, 0, 0, 64'h0,   64'h80, 64'h0,        50,  64'hBAD,      2));
        q.push_back(mk(0, 0, 1, 0, 64'h0,   64'h88, 64'hCAFEF00D, 2,   64'h5555,     0));
        q.push_back(mk(0, 1, 1, 0, 64'h0,   64'h90, 64'h77,       1,   64'h9999,     0));
        q.push_back(mk(0, 1, 0, 0, 64'h0,   64'h94, 64'h0,        1,   64'h4444,     1));
        q.push_back(mk(0, 1, 0, 0, 64'h0,   64'hA8, 64'h0,        TO,  64'h1357,     0));
        q.push_back(mk(0, 1, 0, 0, 64'h0,   64'hB0, 64'h0,        TO+1, 64'h2468,    0));
        for (int i = 0; i < 60; i++) q.push_back(rand_instr());
        run_q();

        // Reset in the middle of an access; the late ack must be ignored.
        drive_instr(mk(0, 1, 0, 0, 64'h0, 64'hA0, 64'h0, 3, 64'h1111, 0));
        @(posedge clk); #1;
        scramble_e();
        @(negedge clk);
        chk("rst_pre_req", dm.dm_req, 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        @(posedge clk); #1;
        reset       = 1'b0;
        exp_rd      = 64'd0;
        dm.dm_ack   = 1'b1;
        dm.dm_rdata = 64'h1111;
        @(negedge clk);
        chk("rst_ack_stall", stall_M, 0);
        chk("rst_ack_req", dm.dm_req, 0);
        @(posedge clk); #1;
        dm.dm_ack = 1'b0;
        repeat (TO + 2) idle_cycle();

        // Normal operation resumes after reset.
        q.delete();
        q.push_back(mk(0, 0, 0, 0, 64'h0, 64'h18, 64'h0, 1, 64'h0,      0));
        q.push_back(mk(0, 1, 0, 0, 64'h0, 64'h20, 64'h0, 2, 64'hABCDEF, 0));
        run_q();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
